// File: rtl/all_gates_pkg.sv
// all_gates_pkg: shared types and constants for the all_gates evaluator.
//   gate_op_e      3-bit gate select applied bitwise to two 2-bit operands
//   RED_*          bit positions inside the 8-bit reduction vector
package all_gates_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

  localparam int RED_AND  = 0;
  localparam int RED_OR   = 1;
  localparam int RED_NAND = 2;
  localparam int RED_NOR  = 3;
  localparam int RED_XOR  = 4;
  localparam int RED_XNOR = 5;
  localparam int RED_BUF  = 6;
  localparam int RED_NOT  = 7;

  localparam int RED_W = 8;

endpackage

// File: rtl/all_gates_if.sv
// all_gates_if: operand/result bundle of the all_gates evaluator.
//   in[3:0]    operand word, A = in[1:0], B = in[3:2]
//   op         gate select
//   in_valid   capture in/op this cycle
//   out[1:0]   registered op(A, B)
//   red[7:0]   registered reduction vector over in[3:0]
//   out_valid  high in the cycle after an accepted input
// master drives the operands (testbench / upstream), slave is the evaluator.
interface all_gates_if;
  import all_gates_pkg::*;

  logic [3:0]       in;
  gate_op_e         op;
  logic             in_valid;
  logic [1:0]       out;
  logic [RED_W-1:0] red;
  logic             out_valid;

  modport master (output in, op, in_valid, input out, red, out_valid);
  modport slave  (input in, op, in_valid, output out, red, out_valid);

endinterface

// File: rtl/gate_alu_2b.sv
// gate_alu_2b: purely combinational 2-bit bitwise gate unit.
//   a[1:0], b[1:0]  operands
//   op              gate select (NOT/BUF ignore b)
//   y[1:0]          op(a, b), bit by bit
module gate_alu_2b
  import all_gates_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  gate_op_e   op,
  output logic [1:0] y
);

  always_comb begin
    // NOTE: y gets a value before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y = a;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/all_gates.sv
// all_gates: registered logic-gate evaluator.
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset; wins over a simultaneous in_valid
//   bus   all_gates_if.slave: in/op/in_valid in, out/red/out_valid out
// One cycle latency; an accepted input loads out and red, otherwise they
// hold. out_valid simply follows in_valid one cycle later. All outputs come
// straight from flops.
module all_gates
  import all_gates_pkg::*;
(
  input logic        clk,
  input logic        rst,
  all_gates_if.slave bus
);

  logic [1:0]       alu_y;
  logic [RED_W-1:0] red_d;

  gate_alu_2b u_alu (
    .a  (bus.in[1:0]),
    .b  (bus.in[3:2]),
    .op (bus.op),
    .y  (alu_y)
  );

  // Reductions span the whole word and do not depend on op.
  always_comb begin
    red_d           = '0;
    red_d[RED_AND]  = &bus.in;
    red_d[RED_OR]   = |bus.in;
    red_d[RED_NAND] = ~&bus.in;
    red_d[RED_NOR]  = ~|bus.in;
    red_d[RED_XOR]  = ^bus.in;
    red_d[RED_XNOR] = ~^bus.in;
    red_d[RED_BUF]  = bus.in[0];
    red_d[RED_NOT]  = ~bus.in[0];
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so ordering between registers in this block cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.red       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= alu_y;
        bus.red <= red_d;
      end
    end
  end

endmodule

// File: tb/tb_all_gates.sv
// tb_all_gates: scoreboard bench for all_gates. Every driven cycle pushes the
// expected result of an accepted input to a queue; one cycle later the result
// is popped and compared against the DUT. Idle and reset cycles check that the
// outputs hold or clear.
module tb_all_gates;
  import all_gates_pkg::*;

  typedef struct packed {
    logic [1:0] out;
    logic [7:0] red;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  all_gates_if bus ();

  all_gates dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  result_t sb_q[$];
  result_t held = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference gate evaluated one bit at a time from truth-table style rules.
  function automatic logic [1:0] ref_out(input logic [3:0] w, input int k);
    logic [1:0] r;
    logic a, b;
    for (int i = 0; i < 2; i++) begin
      a = w[i];
      b = w[i+2];
      case (k)
        0: r[i] = a && b;
        1: r[i] = a || b;
        2: r[i] = !(a && b);
        3: r[i] = !(a || b);
        4: r[i] = a != b;
        5: r[i] = a == b;
        6: r[i] = !a;
        default: r[i] = a;
      endcase
    end
    return r;
  endfunction

  // Reference reductions derived from the population count of the word.
  function automatic logic [7:0] ref_red(input logic [3:0] w);
    int ones = 0;
    logic [7:0] r;
    for (int i = 0; i < 4; i++) ones += int'(w[i]);
    r[0] = (ones == 4);
    r[1] = (ones != 0);
    r[2] = (ones != 4);
    r[3] = (ones == 0);
    r[4] = (ones % 2) == 1;
    r[5] = (ones % 2) == 0;
    r[6] = w[0];
    r[7] = !w[0];
    return r;
  endfunction

  // Drive one cycle, advance past the edge and compare the outcome.
  task automatic step(input logic r, input logic v, input logic [3:0] w, input int k,
                      input string tag);
    result_t exp;
    logic    accepted;
    rst          = r;
    bus.in_valid = v;
    bus.in       = w;
    bus.op       = gate_op_e'(k[2:0]);
    accepted     = v && !r;
    if (r) sb_q.delete();
    if (accepted) sb_q.push_back('{out: ref_out(w, k), red: ref_red(w)});
    @(posedge clk);
    #1;
    if (r) begin
      held = '0;
      check({tag, ".rst_out"}, 32'(bus.out), 32'd0);
      check({tag, ".rst_red"}, 32'(bus.red), 32'd0);
      check({tag, ".rst_vld"}, 32'(bus.out_valid), 32'd0);
    end else if (accepted) begin
      if (sb_q.size() == 0) begin
        check({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        exp  = sb_q.pop_front();
        held = exp;
        check({tag, ".out"}, 32'(bus.out), 32'(exp.out));
        check({tag, ".red"}, 32'(bus.red), 32'(exp.red));
        check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
      end
    end else begin
      check({tag, ".hold_out"}, 32'(bus.out), 32'(held.out));
      check({tag, ".hold_red"}, 32'(bus.red), 32'(held.red));
      check({tag, ".idle_vld"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    bus.in       = 4'b0000;
    bus.op       = OP_AND;
    bus.in_valid = 1'b0;
    #2;

    // Reset with a valid input pending: the input is discarded.
    step(1, 1, 4'b1111, 0, "reset0");
    step(1, 1, 4'b1111, 0, "reset1");

    // Directed patterns.
    step(0, 1, 4'b0000, 0, "and_0000");
    check("red_0000", 32'(bus.red), 32'hAC);
    step(0, 1, 4'b0001, 1, "or_0001");
    check("out_or_0001", 32'(bus.out), 32'd1);
    step(0, 1, 4'b0001, 6, "not_0001");
    check("out_not_0001", 32'(bus.out), 32'd2);
    step(0, 1, 4'b1010, 4, "xor_1010");
    check("out_xor_1010", 32'(bus.out), 32'd0);
    step(0, 1, 4'b1010, 5, "xnor_1010");
    check("out_xnor_1010", 32'(bus.out), 32'd3);
    step(0, 1, 4'b1010, 2, "nand_1010");
    check("out_nand_1010", 32'(bus.out), 32'd1);
    check("red_1010", 32'(bus.red), 32'hA6);
    step(0, 1, 4'b1111, 2, "nand_1111");
    check("out_nand_1111", 32'(bus.out), 32'd0);
    check("red_1111", 32'(bus.red), 32'h63);

    // Idle cycles with changing inputs: outputs must hold.
    for (int i = 0; i < 3; i++) step(0, 0, 4'(i + 3), i, "idle");

    // Back-to-back sweep of all words and gates, reset injected mid-stream.
    for (int i = 0; i < 128; i++) begin
      if (i == 70) step(1, 1, 4'b0110, 4, "sweep_rst");
      step(0, 1, 4'(i / 8), i % 8, "sweep");
    end

    // Reset followed by idle: outputs stay cleared.
    step(1, 0, 4'b1111, 7, "end_rst");
    step(0, 0, 4'b1111, 7, "end_idle");
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
